fabric_reset_ctrl: RTL and testbench

//  Sits downstream of the fabric CCC and runs on its GL0 global clock. Qualifies the asynchronous CCC

---
 rtl/fabric_reset_ctrl.sv | 134 +++++++++++++
 tb/tb_fabric_reset_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fabric_reset_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fabric_reset_ctrl
//  Description : Qualifies the CCC PLL lock and sequences a synchronously
//                released fabric reset, with sticky lock-loss status.
//  Revision    : 1.0  initial release
// ============================================================================
module fabric_reset_ctrl #(
    parameter int LOCK_STABLE_CYCLES = 4,
    parameter int RESET_HOLD_CYCLES  = 8,
    parameter int LOSS_CNT_W         = 8
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  pll_lock,
    input  logic                  sw_rst_req,
    input  logic                  clr_status,
    output logic                  fabric_reset_n,
    output logic [1:0]            state,
    output logic                  pll_lock_lost,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

    localparam int c_CNT_MAX = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                               LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX) + 1;
    localparam logic [c_CNT_W-1:0]    c_STABLE_LAST = c_CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]    c_HOLD_LAST   = c_CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [LOSS_CNT_W-1:0] c_LOSS_MAX    = '1;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABILIZE = 2'd1,
        ST_HOLD      = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    logic                  r_sync_meta;
    logic                  r_lock_s;
    state_t                r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_fabric_reset_n;
    logic                  r_lock_lost;
    logic [LOSS_CNT_W-1:0] r_loss_cnt;
    logic                  w_loss_event;

    // First flop may go metastable; nothing but the second flop reads it.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_sync_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_sync_meta <= pll_lock;
            r_lock_s    <= r_sync_meta;
        end
    end

    assign w_loss_event = !r_lock_s && (r_state == ST_HOLD || r_state == ST_RUN);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state          <= ST_WAIT_LOCK;
            r_cnt            <= '0;
            r_fabric_reset_n <= 1'b0;
        end else begin
            r_fabric_reset_n <= 1'b0;
            case (r_state)
                ST_WAIT_LOCK: begin
                    if (r_lock_s) begin
                        r_state <= ST_STABILIZE;
                        r_cnt   <= '0;
                    end
                end
                ST_STABILIZE: begin
                    if (!r_lock_s) begin
                        r_state <= ST_WAIT_LOCK;
                    end else if (r_cnt == c_STABLE_LAST) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!r_lock_s) begin
                        r_state <= ST_WAIT_LOCK;
                    end else if (r_cnt == c_HOLD_LAST) begin
                        r_state          <= ST_RUN;
                        r_fabric_reset_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    // Lock loss outranks a coincident software request.
                    if (!r_lock_s) begin
                        r_state <= ST_WAIT_LOCK;
                    end else if (sw_rst_req) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= '0;
                    end else begin
                        r_fabric_reset_n <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_WAIT_LOCK;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_lock_lost <= 1'b0;
            r_loss_cnt  <= '0;
        end else begin
            if (w_loss_event) begin
                r_lock_lost <= 1'b1;
                if (r_loss_cnt != c_LOSS_MAX) begin
                    r_loss_cnt <= r_loss_cnt + 1'b1;
                end
            end else if (clr_status) begin
                r_lock_lost <= 1'b0;
            end
        end
    end

    assign fabric_reset_n = r_fabric_reset_n;
    assign state          = r_state;
    assign pll_lock_lost  = r_lock_lost;
    assign lock_loss_cnt  = r_loss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fabric_reset_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fabric_reset_ctrl
//  Description : Self-checking bench for fabric_reset_ctrl (model + literals).
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fabric_reset_ctrl;

    localparam int S = 4;
    localparam int H = 8;
    localparam int W = 8;
    localparam int LOSS_MAX = (1 << W) - 1;

    logic         clk        = 1'b0;
    logic         arst_n     = 1'b0;
    logic         pll_lock   = 1'b1;
    logic         sw_rst_req = 1'b0;
    logic         clr_status = 1'b0;
    logic         fabric_reset_n;
    logic [1:0]   state;
    logic         pll_lock_lost;
    logic [W-1:0] lock_loss_cnt;

    int checks = 0;
    int errors = 0;

    fabric_reset_ctrl #(
        .LOCK_STABLE_CYCLES(S),
        .RESET_HOLD_CYCLES (H),
        .LOSS_CNT_W        (W)
    ) dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .pll_lock      (pll_lock),
        .sw_rst_req    (sw_rst_req),
        .clr_status    (clr_status),
        .fabric_reset_n(fabric_reset_n),
        .state         (state),
        .pll_lock_lost (pll_lock_lost),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_n counts consecutive qualified-high edges since the last
    // return to WAIT_LOCK; the phase is a pure function of that run length.
    int m_n    = 0;
    bit m_s1   = 1'b0;
    bit m_s2   = 1'b0;
    bit m_lost = 1'b0;
    int m_cnt  = 0;
    bit m_ls;
    bit m_loss;

    function automatic int phase_of(input int n);
        if (n == 0)     return 0;
        if (n <= S)     return 1;
        if (n <= S + H) return 2;
        return 3;
    endfunction

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            m_n = 0; m_s1 = 0; m_s2 = 0; m_lost = 0; m_cnt = 0;
        end else begin
            m_ls   = m_s2;
            m_loss = 1'b0;
            if (!m_ls) begin
                m_loss = (phase_of(m_n) >= 2);
                m_n    = 0;
            end else if (phase_of(m_n) == 3 && sw_rst_req) begin
                m_n = S + 1;
            end else if (m_n <= S + H) begin
                m_n = m_n + 1;
            end
            if (m_loss) begin
                m_lost = 1'b1;
                if (m_cnt < LOSS_MAX) m_cnt = m_cnt + 1;
            end else if (clr_status) begin
                m_lost = 1'b0;
            end
            m_s2 = m_s1;
            m_s1 = pll_lock;
        end
    end

    bit cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_state", state, phase_of(m_n));
            chk("model_frst_n", fabric_reset_n, (phase_of(m_n) == 3));
            chk("model_lost", pll_lock_lost, m_lost);
            chk("model_cnt", lock_loss_cnt, m_cnt);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input int target, input int budget, input string name);
        int k;
        for (k = 0; k < budget; k++) begin
            if (state == target[1:0]) break;
            step(1);
        end
        chk(name, state, target);
    endtask

    int low_cnt;
    int run_left;

    initial begin
        // 1: power-up with lock already high
        step(3);
        cmp_en = 1'b1;
        chk("t1_reset_frst_n", fabric_reset_n, 0);
        chk("t1_reset_state", state, 0);
        arst_n = 1'b1;
        step(2);  chk("t1_e2_state", state, 0);
        step(1);  chk("t1_e3_state", state, 1);
        step(3);  chk("t1_e6_state", state, 1);
        step(1);  chk("t1_e7_state", state, 2);
        step(7);  chk("t1_e14_state", state, 2);
                  chk("t1_e14_frst_n", fabric_reset_n, 0);
        step(1);  chk("t1_e15_state", state, 3);
                  chk("t1_e15_frst_n", fabric_reset_n, 1);

        // 2: lock loss in RUN, then relock
        pll_lock = 1'b0;
        step(2);  chk("t2_e2_state", state, 3);
        step(1);  chk("t2_e3_state", state, 0);
                  chk("t2_e3_frst_n", fabric_reset_n, 0);
                  chk("t2_lost", pll_lock_lost, 1);
                  chk("t2_cnt", lock_loss_cnt, 1);
        pll_lock = 1'b1;
        step(14); chk("t2_relock_e14", fabric_reset_n, 0);
        step(1);  chk("t2_relock_e15", fabric_reset_n, 1);

        // 3: dropout during STABILIZE is not a loss event
        pll_lock = 1'b0;
        step(5);  chk("t3_cnt_base", lock_loss_cnt, 2);
        pll_lock = 1'b1;
        step(3);
        pll_lock = 1'b0;
        step(2);
        pll_lock = 1'b1;
        step(1);  chk("t3_back_wait", state, 0);
        step(5);  chk("t3_restab", state, 1);
        step(1);  chk("t3_hold", state, 2);
                  chk("t3_cnt_same", lock_loss_cnt, 2);

        // 4: software reset request
        wait_state(3, 30, "t4_reach_run");
        sw_rst_req = 1'b1;
        step(1);
        sw_rst_req = 1'b0;
        low_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (fabric_reset_n) break;
            low_cnt++;
            step(1);
        end
        chk("t4_sw_low_cycles", low_cnt, H);
        pll_lock = 1'b0;
        step(2);
        sw_rst_req = 1'b1;
        step(1);
        sw_rst_req = 1'b0;
        chk("t4_loss_beats_sw", state, 0);
        chk("t4_cnt", lock_loss_cnt, 3);

        // randomized traffic against the model
        run_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run_left == 0) begin
                pll_lock = ~pll_lock;
                run_left = pll_lock ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 6));
            end else begin
                run_left--;
            end
            sw_rst_req = ($urandom_range(0, 9) == 0);
            clr_status = ($urandom_range(0, 14) == 0);
            step(1);
        end
        sw_rst_req = 1'b0;
        clr_status = 1'b0;
        pll_lock   = 1'b0;
        step(4);

        // 5: saturation and status clear
        for (int k = 0; k < 300; k++) begin
            pll_lock = 1'b1;
            wait_state(2, 20, "t5_reach_hold");
            step($urandom_range(0, 10));
            pll_lock = 1'b0;
            step(4);
        end
        chk("t5_sat_cnt", lock_loss_cnt, 255);
        clr_status = 1'b1;
        step(1);
        clr_status = 1'b0;
        chk("t5_clr_lost", pll_lock_lost, 0);
        chk("t5_clr_cnt", lock_loss_cnt, 255);
        pll_lock = 1'b1;
        wait_state(3, 30, "t5_reach_run");
        pll_lock = 1'b0;
        step(2);
        clr_status = 1'b1;
        step(1);
        clr_status = 1'b0;
        chk("t5_clr_vs_loss", pll_lock_lost, 1);

        // 6: asynchronous reset mid-HOLD
        pll_lock = 1'b1;
        wait_state(2, 20, "t6_reach_hold");
        step(2);
        #2 arst_n = 1'b0;
        #1;
        chk("t6_async_frst_n", fabric_reset_n, 0);
        chk("t6_async_state", state, 0);
        chk("t6_async_lost", pll_lock_lost, 0);
        chk("t6_async_cnt", lock_loss_cnt, 0);
        step(2);
        arst_n = 1'b1;
        step(14); chk("t6_e14_state", state, 2);
                  chk("t6_e14_frst_n", fabric_reset_n, 0);
        step(1);  chk("t6_e15_state", state, 3);
                  chk("t6_e15_frst_n", fabric_reset_n, 1);

        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
